bac_rmw: RTL and testbench

BAC_RMW -- requirements
Module: bac_rmw

---
 rtl/bac_rmw.sv | 103 ++++++++++
 tb/tb_bac_rmw.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bac_rmw.sv
// bac_rmw: byte/word memory access controller; byte stores use read-modify-write.
// Optional word-alignment checking is enabled by defining BAC_ALIGN_CHECK_EN.
module bac_rmw (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        MemWr,
    input  logic        BACOp,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, DONE} state_t;

    state_t      state_q, state_d;
    logic        byte_q, byte_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  lane;
    logic [31:0] merged;
    logic        misalign;

`ifdef BAC_ALIGN_CHECK_EN
    logic err_q;
    assign misalign = !BACOp && (addr[1:0] != 2'b00);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else if (state_q == IDLE && req) err_q <= misalign;
    end
    assign err = err_q && (state_q == DONE);
`else
    assign misalign = 1'b0;
    assign err = 1'b0;
`endif

    // byte lane addr[1:0], little-endian
    always_comb begin
        lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        merged = mem_rdata;
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req) begin
                byte_d  = BACOp;
                addr_d  = addr;
                wdata_d = wdata;
                state_d = misalign ? DONE : !MemWr ? RD : BACOp ? RMW_RD : WR;
            end
            RD: if (mem_ack) begin
                rdata_d = byte_q ? {{24{lane[7]}}, lane} : mem_rdata;
                state_d = DONE;
            end
            RMW_RD: if (mem_ack) begin
                wdata_d = merged;
                state_d = RMW_WR;
            end
            RMW_WR, WR: if (mem_ack) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign ready     = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_re    = state_q == RD || state_q == RMW_RD;
    assign mem_we    = state_q == WR || state_q == RMW_WR;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_bac_rmw.sv
// tb_bac_rmw: directed vectors with a response scoreboard and a memory responder
// that checks each memory transaction against queued expectations.
module tb_bac_rmw;
    logic        clk = 0, reset = 1, req = 0, MemWr = 0, BACOp = 0, mem_ack = 0;
    logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        ready, busy, err, mem_re, mem_we;

    bac_rmw dut (
        .clk(clk), .reset(reset), .req(req), .MemWr(MemWr), .BACOp(BACOp),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
        .err(err), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] rd; logic e;} rsp_t;
    typedef struct packed {logic we; logic [31:0] a; logic [31:0] d;} mem_t;
    rsp_t rsp_q[$];
    mem_t mem_q[$];
    int errors = 0, checks = 0, ready_cnt = 0, ack_cnt = 0, lat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory responder: acks a strobe after lat idle cycles
    initial begin
        int cnt = 0;
        mem_t e;
        forever begin
            @(negedge clk);
            if (reset || !(mem_re || mem_we)) begin
                mem_ack = 0;
                cnt = 0;
            end else if (cnt >= lat) begin
                mem_ack = 1;
                cnt = 0;
                ack_cnt++;
                if (mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected: got re=%b we=%b addr=%h expected no access", mem_re, mem_we, mem_addr);
                end else begin
                    e = mem_q.pop_front();
                    chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
                    chk("mem_addr", mem_addr, e.a);
                    if (e.we) chk("mem_wdata", mem_wdata, e.d);
                end
            end else begin
                mem_ack = 0;
                cnt++;
            end
        end
    end

    // response monitor
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            chk("re_we_exclusive", {31'b0, mem_re && mem_we}, 32'd0);
            if (ready) begin
                ready_cnt++;
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ready_unexpected: got ready=1 expected no response");
                end else begin
                    r = rsp_q.pop_front();
                    chk("rdata", rdata, r.rd);
                    chk("err", {31'b0, err}, {31'b0, r.e});
                end
            end
        end
    end

    task automatic op(input string name, input logic wr, input logic bop, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] mrd, input int l,
                      input logic [31:0] rd_exp, input logic e_exp, input logic has_mem,
                      input logic [31:0] ma, input logic [31:0] wr_exp, input int edges, input logic hold);
        int n = 0;
        bit got = 0;
        @(negedge clk);
        lat = l;
        mem_rdata = mrd;
        MemWr = wr;
        BACOp = bop;
        addr = a;
        wdata = wd;
        if (has_mem && (!wr || bop)) mem_q.push_back('{1'b0, ma, 32'h0});
        if (has_mem && wr) mem_q.push_back('{1'b1, ma, wr_exp});
        rsp_q.push_back('{rd_exp, e_exp});
        req = 1;
        @(posedge clk);
        #1 if (!hold) req = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
                break;
            end
            @(posedge clk);
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ready expected ready", name);
        end else chk({name, "_latency"}, n, edges);
        if (hold) begin
            @(posedge clk);
            #1 req = 0;
            @(negedge clk);
            chk({name, "_busy_after"}, {31'b0, busy}, 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        int a0, r0;
        logic seen;
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_ready", {31'b0, ready}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_strobes", {30'b0, mem_re, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;

        op("wload", 0, 0, 32'h10, 0, 32'h12345678, 3, 32'h12345678, 0, 1, 32'h10, 0, 4, 0);
        op("bload_neg", 0, 1, 32'h13, 0, 32'h80FF0011, 1, 32'hFFFFFF80, 0, 1, 32'h10, 0, 2, 0);
        op("bload_pos", 0, 1, 32'h10, 0, 32'h80FF0011, 0, 32'h00000011, 0, 1, 32'h10, 0, 1, 0);
        op("bload_l2", 0, 1, 32'h12, 0, 32'h80FF0011, 2, 32'hFFFFFFFF, 0, 1, 32'h10, 0, 3, 0);
        op("bstore", 1, 1, 32'h21, 32'hAB, 32'h11223344, 0, 32'hFFFFFFFF, 0, 1, 32'h20, 32'h1122AB44, 2, 0);
        op("bstore_l3", 1, 1, 32'h23, 32'h123456CD, 32'h11223344, 1, 32'hFFFFFFFF, 0, 1, 32'h20, 32'hCD223344, 4, 0);
        op("wstore", 1, 0, 32'h30, 32'hDEADBEEF, 0, 0, 32'hFFFFFFFF, 0, 1, 32'h30, 32'hDEADBEEF, 1, 0);

        a0 = ack_cnt;
        r0 = ready_cnt;
        op("wload_hold", 0, 0, 32'h40, 0, 32'hA5A50F0F, 2, 32'hA5A50F0F, 0, 1, 32'h40, 0, 3, 1);
        chk("hold_acks", ack_cnt - a0, 1);
        chk("hold_readies", ready_cnt - r0, 1);

        // reset while the read-modify-write is in its write phase
        @(negedge clk);
        lat = 4;
        mem_rdata = 32'h55667788;
        MemWr = 1;
        BACOp = 1;
        addr = 32'h50;
        wdata = 32'h99;
        mem_q.push_back('{1'b0, 32'h50, 32'h0});
        req = 1;
        @(posedge clk);
        #1 req = 0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = mem_we;
        end
        chk("rst_mid_we_seen", {31'b0, seen}, 1);
        reset = 1;
        #1;
        chk("rst_mid_we", {31'b0, mem_we}, 0);
        chk("rst_mid_re", {31'b0, mem_re}, 0);
        chk("rst_mid_busy", {31'b0, busy}, 0);
        chk("rst_mid_rdata", rdata, 0);
        chk("rst_mid_mem_wdata", mem_wdata, 0);
        mem_q.delete();
        rsp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | mem_re | mem_we | busy;
        end
        chk("post_rst_quiet", {31'b0, seen}, 0);

`ifdef BAC_ALIGN_CHECK_EN
        op("wload_mis", 0, 0, 32'h06, 0, 32'hCAFEF00D, 0, 32'h0, 1, 0, 0, 0, 0, 0);
        op("wstore_mis", 1, 0, 32'h0A, 32'h01020304, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
`else
        op("wload_mis", 0, 0, 32'h06, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 1, 32'h04, 0, 1, 0);
        op("wstore_mis", 1, 0, 32'h0A, 32'h01020304, 0, 0, 32'hCAFEF00D, 0, 1, 32'h08, 32'h01020304, 1, 0);
`endif
        op("bload_l3", 0, 1, 32'h07, 0, 32'h7F000000, 0, 32'h0000007F, 0, 1, 32'h04, 0, 1, 0);

        repeat (3) @(negedge clk);
        chk("sb_rsp_empty", rsp_q.size(), 0);
        chk("sb_mem_empty", mem_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
